// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Programmable serial sequence detector with start/abort control,
//            overlapping / non-overlapping matching and a match-count target.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
  parameter int                MAXLEN      = 8,
  parameter int                CNTW        = 8,
  parameter logic [MAXLEN-1:0] DEF_PATTERN = MAXLEN'(8'b0000_0110),
  parameter int                DEF_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cfg_we,
  input  logic [MAXLEN-1:0]            cfg_pattern,
  input  logic [$clog2(MAXLEN+1)-1:0]  cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNTW-1:0]              cfg_target,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic                         in,
  output logic                         match,
  output logic [CNTW-1:0]              count,
  output logic                         busy,
  output logic                         done
);

  localparam int LW = $clog2(MAXLEN+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [MAXLEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]     len_q, len_d;
  logic              overlap_q, overlap_d;
  logic [CNTW-1:0]   target_q, target_d;
  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [LW-1:0]     fill_q, fill_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              match_q, match_d;
  logic              cfg_err_q, cfg_err_d;

  logic [MAXLEN-1:0] w_hist_n;
  logic [LW-1:0]     w_fill_n;
  logic [MAXLEN-1:0] w_mask;
  logic              w_hit;
  logic              w_beat;
  logic              w_arm;
  logic              w_final;
  logic              w_len_ok;

  // Shared match evaluation for the current beat and the control qualifiers
  always_comb begin
    w_hist_n = {hist_q[MAXLEN-2:0], in};
    w_fill_n = (fill_q < len_q) ? fill_q + LW'(1) : fill_q;
    for (int i = 0; i < MAXLEN; i++) begin
      w_mask[i] = (LW'(i) < len_q);
    end
    w_hit    = (w_fill_n >= len_q) && (((w_hist_n ^ pattern_q) & w_mask) == '0);
    w_beat   = (state_q == S_RUN) && in_valid && !abort;
    w_arm    = (state_q != S_RUN) && start && !abort;
    // Only a real target can end a run; target 0 means run forever
    w_final  = w_beat && w_hit && (target_q != '0) &&
               ((count_q + CNTW'(1)) == target_q);
    w_len_ok = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort wins over everything else
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_arm) state_d = S_RUN;
      S_RUN: begin
        if (abort)        state_d = S_IDLE;
        else if (w_final) state_d = S_DONE;
      end
      S_DONE: begin
        if (abort)      state_d = S_IDLE;
        else if (w_arm) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Config, history, fill and counter next values
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    if ((state_q == S_IDLE) && cfg_we) begin
      if (w_len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        target_d  = cfg_target;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (w_arm) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (w_beat) begin
      hist_d = w_hist_n;
      fill_d = w_fill_n;
      if (w_hit) begin
        match_d = 1'b1;
        count_d = (count_q == {CNTW{1'b1}}) ? count_q : count_q + CNTW'(1);
        // Non-overlapping mode demands len fresh bits before the next match
        if (!overlap_q) fill_d = '0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LW'(DEF_LEN);
      overlap_q <= 1'b1;
      target_q  <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign match   = match_q;
  assign count   = count_q;
  assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Brief    : Directed, table-driven bench for seq_det_ctrl. A second instance
//            with a 2-bit counter shares the stimulus for saturation checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;

  logic       cfg_err, match, busy, done;
  logic [7:0] count;
  logic       cfg_err2, match2, busy2, done2;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  seq_det_ctrl dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .cfg_err(cfg_err), .start(start), .abort(abort), .in_valid(in_valid),
    .in(in), .match(match), .count(count), .busy(busy), .done(done)
  );

  seq_det_ctrl #(.CNTW(2)) dut2 (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]),
    .cfg_err(cfg_err2), .start(start), .abort(abort), .in_valid(in_valid),
    .in(in), .match(match2), .count(count2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       b;
    logic       m;
    logic [7:0] c;
    logic       d;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic b);
    in_valid = v;
    in       = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic [7:0] t);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    cfg_target  = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      beat(vecs[i].v, vecs[i].b);
      chk($sformatf("vec%0d match", i), 32'(match), 32'(vecs[i].m));
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].c));
      chk($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].d));
      chk($sformatf("vec%0d busy", i),  32'(busy),  32'(!vecs[i].d));
    end
  endtask

  task automatic set_vec(input int i, input logic b, input logic m, input logic [7:0] c,
                         input logic d);
    vecs[i] = '{v: 1'b1, b: b, m: m, c: c, d: d};
  endtask

  initial begin
    // Default pattern 0110, overlapping: matches after beats 4 and 7
    set_vec(0, 0, 0, 0, 0); set_vec(1, 1, 0, 0, 0); set_vec(2, 1, 0, 0, 0);
    set_vec(3, 0, 1, 1, 0); set_vec(4, 1, 0, 1, 0); set_vec(5, 1, 0, 1, 0);
    set_vec(6, 0, 1, 2, 0);
    // Same stream, non-overlapping: only the first match
    set_vec(7, 0, 0, 0, 0);  set_vec(8, 1, 0, 0, 0);  set_vec(9, 1, 0, 0, 0);
    set_vec(10, 0, 1, 1, 0); set_vec(11, 1, 0, 1, 0); set_vec(12, 1, 0, 1, 0);
    set_vec(13, 0, 0, 1, 0);
    // Pattern 10, target 3: third match arrives with done
    set_vec(14, 1, 0, 0, 0); set_vec(15, 0, 1, 1, 0); set_vec(16, 1, 0, 1, 0);
    set_vec(17, 0, 1, 2, 0); set_vec(18, 1, 0, 2, 0); set_vec(19, 0, 1, 3, 1);
    set_vec(20, 1, 0, 3, 1); set_vec(21, 0, 0, 3, 1);

    // Reset state
    #2;
    chk("rst match", 32'(match), 0);
    chk("rst count", 32'(count), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst cfg_err", 32'(cfg_err), 0);
    tick();
    rstn = 1'b1;
    tick();

    // Default config detection
    do_start();
    chk("start busy", 32'(busy), 1);
    run_vecs(0, 6);

    // Non-overlapping mode
    do_abort();
    chk("abort busy", 32'(busy), 0);
    chk("abort keeps count", 32'(count), 2);
    cfg_write(8'h06, 4'd4, 1'b0, 8'd0);
    chk("good write no err", 32'(cfg_err), 0);
    do_start();
    run_vecs(7, 13);

    // Target stop
    do_abort();
    cfg_write(8'h02, 4'd2, 1'b1, 8'd3);
    do_start();
    run_vecs(14, 21);

    // Write in DONE is silently ignored
    cfg_write(8'h01, 4'd1, 1'b1, 8'd0);
    chk("done write no err", 32'(cfg_err), 0);
    do_start();
    chk("restart from done count", 32'(count), 0);
    chk("restart from done busy", 32'(busy), 1);
    chk("restart from done done", 32'(done), 0);
    do_abort();

    // Rejected writes in IDLE
    cfg_write(8'hff, 4'd0, 1'b0, 8'd0);
    chk("len0 cfg_err", 32'(cfg_err), 1);
    tick();
    chk("cfg_err pulse ends", 32'(cfg_err), 0);
    cfg_write(8'hff, 4'd9, 1'b0, 8'd0);
    chk("len9 cfg_err", 32'(cfg_err), 1);
    do_start();
    beat(1, 1);
    beat(1, 0);
    chk("old cfg match", 32'(match), 1);
    chk("old cfg count", 32'(count), 1);
    cfg_write(8'h03, 4'd2, 1'b1, 8'd0);
    chk("run write no err", 32'(cfg_err), 0);
    beat(1, 1);
    beat(1, 1);
    chk("run write ignored 11", 32'(match), 0);
    beat(1, 0);
    chk("still pattern 10", 32'(match), 1);
    beat(1, 1);
    beat(1, 0);
    chk("target kept count", 32'(count), 3);
    chk("target kept done", 32'(done), 1);

    // in_valid gaps, then abort on the completing beat
    do_abort();
    cfg_write(8'h06, 4'd4, 1'b1, 8'd0);
    do_start();
    beat(1, 0); chk("gap b1", 32'(match), 0);
    beat(0, 1); chk("gap b2", 32'(match), 0);
    beat(1, 1); chk("gap b3", 32'(match), 0);
    beat(0, 0); chk("gap b4", 32'(match), 0);
    beat(1, 1); chk("gap b5", 32'(match), 0);
    beat(0, 1); chk("gap b6", 32'(match), 0);
    beat(1, 0); chk("gap b7", 32'(match), 1);
    chk("gap count", 32'(count), 1);
    beat(1, 1);
    beat(1, 1);
    chk("pre-abort no match", 32'(match), 0);
    abort = 1'b1;
    beat(1, 0);
    abort = 1'b0;
    chk("abort beat match", 32'(match), 0);
    chk("abort beat count", 32'(count), 1);
    chk("abort beat busy", 32'(busy), 0);
    chk("abort beat done", 32'(done), 0);
    beat(1, 0);
    chk("idle beat ignored", 32'(match), 0);

    // Saturation on the 2-bit counter instance, back-to-back matches
    cfg_write(8'h01, 4'd1, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 6; i++) begin
      beat(1, 1);
      chk($sformatf("sat%0d match2", i), 32'(match2), 1);
      chk($sformatf("sat%0d count2", i), 32'(count2), (i < 3) ? i + 1 : 3);
    end
    do_abort();
    chk("sat abort count2", 32'(count2), 3);
    do_start();
    chk("idle start count2", 32'(count2), 0);
    do_abort();
    cfg_write(8'h01, 4'd1, 1'b1, 8'd2);
    do_start();
    beat(1, 1);
    beat(1, 1);
    chk("t2 done2", 32'(done2), 1);
    chk("t2 count2", 32'(count2), 2);
    do_start();
    chk("done start count2", 32'(count2), 0);
    chk("done start busy2", 32'(busy2), 1);

    // Asynchronous reset in the middle of a run
    beat(1, 1);
    chk("pre-reset count", 32'(count), 1);
    #3 rstn = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 0);
    chk("async rst count", 32'(count), 0);
    #2 rstn = 1'b1;
    tick();
    do_start();
    beat(1, 0);
    beat(1, 1);
    beat(1, 1);
    beat(1, 0);
    chk("post-reset default match", 32'(match), 1);
    chk("post-reset count", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
